ysyx_22050854_alu_divider: RTL and testbench
============================================

// Module: ysyx_22050854_alu_divider
// PURPOSE
//  Multi-cycle RV64M divide/remainder unit downstream of the ALU operand source mux; consumes
//  alu_src1 (dividend) and alu_src2 (divisor) for DIV/DIVU/REM/REMU/DIVW/DIVUW/REMW/REMUW.
//  Radix-2 restoring algorithm on magnitudes, one quotient bit per cycle, valid/ready on both
//  sides so EX can stall while busy. Flush aborts an in-flight op (branch mispredict/trap).
// PARAMETERS
//  XLEN   64  datapath width; only 64 is supported (word ops defined against 64)
//  CNT_W  7   iteration counter width; must hold XLEN
// PORTS
//  clk         in   1     clock, all state updates on rising edge
//  rst_n       in   1     synchronous reset, active-low
//  flush       in   1     abort current op, return to IDLE
//  in_valid    in   1     operands/opcode valid
//  in_ready    out  1     unit can accept (state==IDLE); combinational from state only
//  src1        in   XLEN  dividend (alu_src1)
//  src2        in   XLEN  divisor (alu_src2)
//  div_signed  in   1     1: signed (DIV/REM[W]), 0: unsigned
//  div_word    in   1     1: W-variant, operate on low 32 bits, sign-extend result
//  div_rem     in   1     1: return remainder, 0: return quotient
//  out_valid   out  1     result valid
//  out_ready   in   1     consumer takes result
//  result      out  XLEN  selected quotient/remainder, stable while out_valid
//  busy        out  1     state!=IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, out_valid=0, result=0, in_ready=1, busy=0, counter=0.
//  States: IDLE -> CALC -> DONE -> IDLE; IDLE -> DONE directly for divide-by-zero.
//  Accept: edge E0 with in_valid&&in_ready&&!flush. Latch div_signed/div_word/div_rem.
//  Operand prep at E0: word ops take src[31:0] sign-extended (signed) or zero-extended
//   (unsigned) to 64. Signed: record neg_q = sign(a)^sign(b), neg_r = sign(a); use |a|,|b|
//   as 64-bit unsigned (|-2^63| = 2^63 representable).
//  CALC: edges E1..E64 each perform one restoring step (shift rem:quo left 1, trial-subtract
//   divisor, set quotient bit if no borrow). At E64: apply sign fix (negate q if neg_q, r if
//   neg_r), word ops take low 32 and sign-extend, select by div_rem, register result,
//   state=DONE, out_valid=1. Normal latency: out_valid high in cycle after E64.
//  Divide-by-zero (divisor after word-truncation ==0): at E0 go straight to DONE;
//   quotient=all ones (word: 0xFFFFFFFF_FFFFFFFF), remainder=prepared dividend
//   (word: sext of src1[31:0]). out_valid high in cycle after E0.
//  Overflow (-2^63/-1, word -2^31/-1): no special path; algorithm yields q=dividend, r=0.
//  DONE: hold result and out_valid until out_valid&&out_ready edge -> IDLE, out_valid=0.
//   No new op accepted in DONE (in_ready=0); back-to-back ops cost one IDLE cycle.
//  flush: at any edge with flush=1 (and rst_n=1), state=IDLE, out_valid=0, counter=0; flush
//   beats accept and beats DONE handoff (result discarded even if out_ready=1).
//  Reset mid-operation behaves like flush plus result=0.
//  Inputs src1/src2/opcode bits ignored except at accepting edge.
// TESTING
//  DIVU 100/7 accept E0 -> out_valid after E64, result=14; repeat div_rem=1 -> result=2.
//  DIV -7/2 -> quotient 0xFFFF_FFFF_FFFF_FFFD (-3); REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF (-1).
//  DIV 0x8000_0000_0000_0000 / -1 -> q=0x8000_0000_0000_0000, REM -> 0; DIVW 0x8000_0000/-1
//   -> 0xFFFF_FFFF_8000_0000.
//  DIVU x/0 and REMW 0x1_8000_0005/0x1_0000_0000 (word divisor 0): q=all ones after 1 cycle;
//   REMW result=0xFFFF_FFFF_8000_0005.
//  Hold out_ready=0 for 10 cycles in DONE -> result/out_valid stable, in_ready=0; then
//   out_ready=1 -> IDLE next edge.
//  flush at E30 of CALC -> IDLE next edge, no out_valid; flush with in_valid in IDLE -> not
//   accepted; rst_n=0 during CALC -> all outputs at reset values.

Source files
------------

// File: rtl/ysyx_22050854_alu_divider_if.sv
// Handshake and operand bus between EX and the multi-cycle divide/remainder unit.
// The master side is EX. The slave side is the divider.
interface ysyx_22050854_alu_divider_if #(
    parameter int XLEN = 64
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            div_signed;
    logic            div_word;
    logic            div_rem;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output flush, in_valid, src1, src2, div_signed, div_word, div_rem, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  flush, in_valid, src1, src2, div_signed, div_word, div_rem, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/ysyx_22050854_alu_divider.sv
// RV64M divide/remainder unit. It runs a radix-2 restoring divide on operand magnitudes.
// It produces one quotient bit per cycle and applies the sign fix when it finishes.
module ysyx_22050854_alu_divider #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input logic                   clk,
    input logic                   rst_n,
    ysyx_22050854_alu_divider_if.slave dif
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  rem_q, quo_q, dvs_q, result_q;
    logic             neg_q, neg_r, word_q, sel_rem;

    logic [XLEN-1:0]  a_prep, b_prep, a_mag, b_mag, dz_res;
    logic             accept, div_zero;

    logic [XLEN:0]    trial;
    logic [XLEN-1:0]  step_rem, step_quo, q_fix, r_fix, pick, fin_res;

    assign accept   = (state == ST_IDLE) && dif.in_valid;
    assign div_zero = (b_prep == '0);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        a_prep = dif.src1;
        b_prep = dif.src2;
        if (dif.div_word) begin
            a_prep = dif.div_signed ? {{(XLEN-32){dif.src1[31]}}, dif.src1[31:0]}
                                    : {{(XLEN-32){1'b0}}, dif.src1[31:0]};
            b_prep = dif.div_signed ? {{(XLEN-32){dif.src2[31]}}, dif.src2[31:0]}
                                    : {{(XLEN-32){1'b0}}, dif.src2[31:0]};
        end
        // |-2^63| wraps back to 2^63. That value is still correct when read as unsigned.
        a_mag = (dif.div_signed && a_prep[XLEN-1]) ? -a_prep : a_prep;
        b_mag = (dif.div_signed && b_prep[XLEN-1]) ? -b_prep : b_prep;
        dz_res = '1;
        if (dif.div_rem)
            dz_res = dif.div_word ? {{(XLEN-32){a_prep[31]}}, a_prep[31:0]} : a_prep;
    end

    // This is one restoring step. The 65-bit trial keeps the bit that is shifted out of rem.
    always_comb begin
        trial    = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
        step_rem = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
        step_quo = {quo_q[XLEN-2:0], ~trial[XLEN]};
        q_fix    = neg_q ? -step_quo : step_quo;
        r_fix    = neg_r ? -step_rem : step_rem;
        pick     = sel_rem ? r_fix : q_fix;
        fin_res  = word_q ? {{(XLEN-32){pick[31]}}, pick[31:0]} : pick;
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            result_q <= '0;
        end else if (dif.flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (dif.in_valid) begin
                    cnt <= '0;
                    if (div_zero) begin
                        state    <= ST_DONE;
                        result_q <= dz_res;
                    end else begin
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        state    <= ST_DONE;
                        cnt      <= '0;
                        result_q <= fin_res;
                    end
                end
                ST_DONE: if (dif.out_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the datapath registers are left unreset on purpose. Each accept loads them before any use.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_q   <= '0;
            quo_q   <= a_mag;
            dvs_q   <= b_mag;
            neg_q   <= dif.div_signed & (a_prep[XLEN-1] ^ b_prep[XLEN-1]);
            neg_r   <= dif.div_signed & a_prep[XLEN-1];
            word_q  <= dif.div_word;
            sel_rem <= dif.div_rem;
        end else if (state == ST_CALC) begin
            rem_q <= step_rem;
            quo_q <= step_quo;
        end
    end

    assign dif.in_ready  = (state == ST_IDLE);
    assign dif.busy      = (state != ST_IDLE);
    assign dif.out_valid = (state == ST_DONE);
    assign dif.result    = result_q;
endmodule

// File: tb/tb_ysyx_22050854_alu_divider.sv
// Directed bench for the RV64M divider: a table of vectors plus hand-written
// sequences for stall, flush and mid-operation reset.
module tb_ysyx_22050854_alu_divider;
    typedef struct {
        string       name;
        logic        sgn;
        logic        wrd;
        logic        rem;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 18;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[NV];

    ysyx_22050854_alu_divider_if #(.XLEN(64)) dif ();

    ysyx_22050854_alu_divider #(.XLEN(64), .CNT_W(7)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .dif  (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // The operation is accepted at the posedge (E0). After that, the operand and opcode pins are scrambled.
    task automatic start_op(input logic s, input logic w, input logic r,
                            input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        dif.div_signed = s;
        dif.div_word   = w;
        dif.div_rem    = r;
        dif.src1       = a;
        dif.src2       = b;
        dif.in_valid   = 1'b1;
        @(posedge clk);
        #1;
        dif.in_valid   = 1'b0;
        dif.src1       = {$urandom, $urandom};
        dif.src2       = {$urandom, $urandom};
        dif.div_signed = ~s;
        dif.div_word   = ~w;
        dif.div_rem    = ~r;
    endtask

    // This returns the number of edges after E0 before out_valid is seen, with a bound of 200.
    task automatic wait_valid(output int edges);
        @(negedge clk);
        edges = 0;
        while (!dif.out_valid && edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int edges;
        start_op(v.sgn, v.wrd, v.rem, v.a, v.b);
        wait_valid(edges);
        check({v.name, " latency"}, 64'(edges), 64'(v.lat));
        check({v.name, " result"}, dif.result, v.exp);
        @(negedge clk);
        check({v.name, " handoff"}, {62'd0, dif.in_ready, dif.out_valid}, 64'h2);
    endtask

    initial begin
        int edges;
        int seen;

        vecs[0]  = '{"divu_100_7",   1'b0, 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64};
        vecs[1]  = '{"remu_100_7",   1'b0, 1'b0, 1'b1, 64'd100, 64'd7, 64'd2, 64};
        vecs[2]  = '{"div_m7_2",     1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                     64'hFFFF_FFFF_FFFF_FFFD, 64};
        vecs[3]  = '{"rem_m7_2",     1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                     64'hFFFF_FFFF_FFFF_FFFF, 64};
        vecs[4]  = '{"div_7_m2",     1'b1, 1'b0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
                     64'hFFFF_FFFF_FFFF_FFFD, 64};
        vecs[5]  = '{"rem_7_m2",     1'b1, 1'b0, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64};
        vecs[6]  = '{"div_ovf",      1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64};
        vecs[7]  = '{"rem_ovf",      1'b1, 1'b0, 1'b1, 64'h8000_0000_0000_0000,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64};
        vecs[8]  = '{"divw_ovf",     1'b1, 1'b1, 1'b0, 64'h0000_0000_8000_0000,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64};
        vecs[9]  = '{"divu_max_msb", 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'h8000_0000_0000_0000, 64'd1, 64};
        vecs[10] = '{"remu_max_msb", 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64};
        vecs[11] = '{"divuw_junk",   1'b0, 1'b1, 1'b0, 64'hABCD_0000_FFFF_FFFF, 64'd2,
                     64'h0000_0000_7FFF_FFFF, 64};
        vecs[12] = '{"remw_m7_2",    1'b1, 1'b1, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2,
                     64'hFFFF_FFFF_FFFF_FFFF, 64};
        vecs[13] = '{"divu_by0",     1'b0, 1'b0, 1'b0, 64'd12345, 64'd0,
                     64'hFFFF_FFFF_FFFF_FFFF, 0};
        vecs[14] = '{"remu_by0",     1'b0, 1'b0, 1'b1, 64'd12345, 64'd0, 64'd12345, 0};
        vecs[15] = '{"remw_wzero",   1'b1, 1'b1, 1'b1, 64'h0000_0001_8000_0005,
                     64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0005, 0};
        vecs[16] = '{"divw_wzero",   1'b1, 1'b1, 1'b0, 64'h0000_0001_8000_0005,
                     64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0};
        vecs[17] = '{"rem_m5_by0",   1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0,
                     64'hFFFF_FFFF_FFFF_FFFB, 0};

        rst_n          = 1'b0;
        dif.flush      = 1'b0;
        dif.in_valid   = 1'b0;
        dif.src1       = '0;
        dif.src2       = '0;
        dif.div_signed = 1'b0;
        dif.div_word   = 1'b0;
        dif.div_rem    = 1'b0;
        dif.out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset flags", {60'd0, dif.in_ready, dif.busy, dif.out_valid, 1'b0}, 64'h8);
        check("reset result", dif.result, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        // While out_ready is held low in DONE, the result and flags stay frozen for 10 cycles.
        dif.out_ready = 1'b0;
        start_op(1'b0, 1'b0, 1'b0, 64'd100, 64'd7);
        wait_valid(edges);
        check("stall latency", 64'(edges), 64'd64);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (dif.out_valid && !dif.in_ready && dif.busy && dif.result == 64'd14) seen++;
        end
        check("stall hold cycles", 64'(seen), 64'd10);
        dif.out_ready = 1'b1;
        @(negedge clk);
        check("stall release", {62'd0, dif.in_ready, dif.out_valid}, 64'h2);

        // Flush is asserted on edge E30 of CALC.
        start_op(1'b0, 1'b0, 1'b0, 64'd1000, 64'd3);
        repeat (29) @(posedge clk);
        @(negedge clk);
        check("pre-flush busy", {63'd0, dif.busy}, 64'd1);
        dif.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dif.flush = 1'b0;
        check("flush idle", {61'd0, dif.in_ready, dif.busy, dif.out_valid}, 64'h4);
        seen = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (dif.out_valid) seen++;
        end
        check("flush no out_valid", 64'(seen), 64'd0);

        // When flush and in_valid arrive together in IDLE, the operation is not accepted.
        @(negedge clk);
        dif.flush      = 1'b1;
        dif.in_valid   = 1'b1;
        dif.src1       = 64'd9;
        dif.src2       = 64'd0;
        dif.div_signed = 1'b0;
        dif.div_word   = 1'b0;
        dif.div_rem    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        dif.flush    = 1'b0;
        dif.in_valid = 1'b0;
        check("flush beats accept", {61'd0, dif.in_ready, dif.busy, dif.out_valid}, 64'h4);

        // Reset during CALC must also clear the previous result.
        check("pre-reset result", dif.result, 64'd14);
        start_op(1'b0, 1'b0, 1'b0, 64'd500, 64'd9);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid reset flags", {61'd0, dif.in_ready, dif.busy, dif.out_valid}, 64'h4);
        check("mid reset result", dif.result, 64'd0);
        rst_n = 1'b1;

        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
